// File: rtl/a5_1_pkg.sv
// a5_1_pkg
// Constants and types shared by the A5/1 keystream engine:
//   - LFSR lengths, feedback tap masks and clocking-bit positions for R1/R2/R3
//   - shared phase counter width and the phase lengths (key, frame, mix)
//   - FSM state encoding
//   - majority-of-three helper used for irregular clocking
package a5_1_pkg;

  localparam int unsigned R1_LEN = 19;
  localparam int unsigned R2_LEN = 22;
  localparam int unsigned R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;   // bits 13,16,17,18
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;  // bits 20,21
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;  // bits 7,20,21,22

  localparam int unsigned R1_CLK_BIT = 8;
  localparam int unsigned R2_CLK_BIT = 10;
  localparam int unsigned R3_CLK_BIT = 10;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned KEY_LEN   = 64;
  localparam int unsigned FRAME_LEN = 22;
  // 100 discard clocks plus the clock that precedes the first output bit
  localparam int unsigned MIX_LEN   = 101;

  localparam cnt_t KEY_LAST   = cnt_t'(KEY_LEN - 1);
  localparam cnt_t FRAME_LAST = cnt_t'(FRAME_LEN - 1);
  localparam cnt_t MIX_LAST   = cnt_t'(MIX_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_KEY   = 3'd1,
    ST_LOAD_FRAME = 3'd2,
    ST_MIX        = 3'd3,
    ST_OUT        = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_1_keystream_reg.sv
// a5_1_reg
// One A5/1 linear feedback shift register with a serial load input.
// A step shifts left; the new bit 0 is the XOR of the tapped bits XOR d.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - synchronous active-low reset, clears the register
//   clr      - synchronous clear (frame start / abort), wins over step
//   step     - advance the register this cycle
//   d        - serial input folded into the feedback bit
//   q_msb    - register MSB (keystream contribution)
//   q_clk    - clocking bit used by the majority rule
module a5_1_reg #(
  parameter int unsigned      LEN     = 19,
  parameter logic [LEN-1:0]   TAPS    = '0,
  parameter int unsigned      CLK_BIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic step,
  input  logic d,
  output logic q_msb,
  output logic q_clk
);

  logic [LEN-1:0] r;
  logic           fb;

  always_comb begin
    fb = (^(r & TAPS)) ^ d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r <= '0;
    end else if (clr) begin
      r <= '0;
    end else if (step) begin
      r <= {r[LEN-2:0], fb};
    end
  end

  assign q_msb = r[LEN-1];
  assign q_clk = r[CLK_BIT];

endmodule

// File: rtl/a5_1_keystream.sv
// a5_1_keystream
// A5/1 keystream engine. On start (in IDLE) it captures the session key and
// frame number, loads them serially into R1/R2/R3 (key[0] / frame[0] first),
// runs the majority-clocked mixing phase and then streams NUM_KS_BITS
// keystream bits over a valid/ready handshake, followed by a one-cycle done.
// Optional feature: define A5_1_ABORT_EN to add the abort input, which returns
// any busy frame to IDLE on the next edge with the registers zeroed.
// Ports:
//   clk       - clock, rising edge
//   reset_n   - synchronous active-low reset
//   abort     - (A5_1_ABORT_EN only) cancel the current frame
//   start     - begin a frame, honoured only in IDLE
//   key       - 64-bit session key
//   frame     - 22-bit frame number
//   ks_ready  - consumer accepts ks_bit this cycle
//   ks_valid  - ks_bit is valid
//   ks_bit    - keystream bit R1[18]^R2[21]^R3[22]
//   busy      - high whenever not IDLE
//   done      - one-cycle pulse after the last accepted keystream bit
module a5_1_keystream
  import a5_1_pkg::*;
#(
  parameter int unsigned NUM_KS_BITS = 228
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef A5_1_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  input  logic        ks_ready,
  output logic        ks_valid,
  output logic        ks_bit,
  output logic        busy,
  output logic        done
);

  localparam cnt_t KS_LAST = cnt_t'(NUM_KS_BITS - 1);

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [63:0] key_q;
  logic [21:0] frame_q;

  logic clr, step_all, maj_en, d;
  logic maj;
  logic step1, step2, step3;
  logic r1_msb, r2_msb, r3_msb;
  logic r1_clk, r2_clk, r3_clk;
  logic abort_req;

`ifdef A5_1_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign maj   = majority3(r1_clk, r2_clk, r3_clk);
  assign step1 = step_all | (maj_en & (r1_clk == maj));
  assign step2 = step_all | (maj_en & (r2_clk == maj));
  assign step3 = step_all | (maj_en & (r3_clk == maj));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr      = 1'b0;
    step_all = 1'b0;
    maj_en   = 1'b0;
    d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD_KEY;
        end
      end
      ST_LOAD_KEY: begin
        step_all = 1'b1;
        d        = key_q[cnt_q[5:0]];
        if (cnt_q == KEY_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOAD_FRAME;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_LOAD_FRAME: begin
        step_all = 1'b1;
        d        = frame_q[cnt_q[4:0]];
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = ST_MIX;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_MIX: begin
        maj_en = 1'b1;
        if (cnt_q == MIX_LAST) begin
          cnt_d   = '0;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_OUT: begin
        // the bit on ks_bit is the one accepted; the clock prepares the next
        if (ks_ready) begin
          maj_en = 1'b1;
          if (cnt_q == KS_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // abort overrides the handshake and any phase progress
    if (abort_req && (state_q != ST_IDLE)) begin
      clr      = 1'b1;
      step_all = 1'b0;
      maj_en   = 1'b0;
      cnt_d    = '0;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == ST_IDLE) && start) begin
        key_q   <= key;
        frame_q <= frame;
      end
    end
  end

  a5_1_reg #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK_BIT)) u_r1 (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .step    (step1),
    .d       (d),
    .q_msb   (r1_msb),
    .q_clk   (r1_clk)
  );

  a5_1_reg #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK_BIT)) u_r2 (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .step    (step2),
    .d       (d),
    .q_msb   (r2_msb),
    .q_clk   (r2_clk)
  );

  a5_1_reg #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK_BIT)) u_r3 (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .step    (step3),
    .d       (d),
    .q_msb   (r3_msb),
    .q_clk   (r3_clk)
  );

  assign ks_valid = (state_q == ST_OUT);
  assign ks_bit   = r1_msb ^ r2_msb ^ r3_msb;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_a5_1_keystream.sv
// tb_a5_1_keystream
// Directed bench for a5_1_keystream: golden frame, backpressure, ignored
// restarts, mid-frame resets, all-zero frame and (A5_1_ABORT_EN) abort.
// Expected keystream bits are queued when a frame is launched and popped by
// a monitor on every accepted handshake.
module tb_a5_1_keystream;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [63:0] key;
  logic [21:0] frame;
  logic        ks_ready;
  logic        ks_valid;
  logic        ks_bit;
  logic        busy;
  logic        done;
`ifdef A5_1_ABORT_EN
  logic        abort;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic exp_q[$];
  logic prev_stall = 1'b0;
  logic prev_bit   = 1'b0;

  logic [63:0]  gold_key;
  logic [21:0]  gold_frame;
  logic [227:0] gold;
  logic [227:0] zero_bits;
  logic [119:0] hex_ab;
  logic [119:0] hex_ba;

  a5_1_keystream #(.NUM_KS_BITS(228)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
`ifdef A5_1_ABORT_EN
    .abort    (abort),
`endif
    .start    (start),
    .key      (key),
    .frame    (frame),
    .ks_ready (ks_ready),
    .ks_valid (ks_valid),
    .ks_bit   (ks_bit),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard consumer: every accepted bit is compared, stalled bits must hold
  always @(negedge clk) begin
    logic e;
    if (ks_valid === 1'b1) begin
      if (prev_stall) begin
        total++;
        assert (ks_bit === prev_bit) else begin
          bad++;
          $error("FAIL ks_hold observed=%b expected=%b", ks_bit, prev_bit);
        end
      end
      if (ks_ready === 1'b1) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL ks_extra observed=%b expected=none", ks_bit);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          total++;
          assert (ks_bit === e) else begin
            bad++;
            $error("FAIL ks_bit observed=%b expected=%b", ks_bit, e);
          end
        end
      end
      prev_stall = (ks_ready !== 1'b1);
      prev_bit   = ks_bit;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_bits(input logic [227:0] bits);
    for (int i = 0; i < 228; i++) exp_q.push_back(bits[227-i]);
  endtask

  // start sampled at edge 0; returns in cycle 1 with inputs scrambled
  task automatic launch(input logic [63:0] k, input logic [21:0] f);
    key   = k;
    frame = f;
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc   = 1;
    start = 1'b0;
    key   = {$urandom, $urandom};
    frame = 22'($urandom);
  endtask

  task automatic run_frame(input logic [63:0] k, input logic [21:0] f,
                           input logic [227:0] bits, input bit bp, input bit pulses);
    int first_valid;
    int done_cyc;
    first_valid = -1;
    done_cyc    = -1;
    exp_q.delete();
    push_bits(bits);
    ks_ready = 1'b1;
    launch(k, f);
    chk("busy_rise", 32'(busy), 32'd1);
    while (cyc < 3000) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (ks_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      ks_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = pulses && (cyc == 5 || cyc == 190);
      tick();
    end
    start = 1'b0;
    chk("first_valid", 32'(first_valid), 32'd188);
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    if (!bp) chk("done_cycle", 32'(done_cyc), 32'd416);
    chk("bits_left", 32'(exp_q.size()), 32'd0);
    ks_ready = 1'b1;
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(ks_valid), 32'd0);
    exp_q.delete();
  endtask

  task automatic reset_at(input int when);
    exp_q.delete();
    push_bits(gold);
    ks_ready = 1'b1;
    launch(gold_key, gold_frame);
    while (cyc < when) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst_valid", 32'(ks_valid), 32'd0);
    chk("rst_bit", 32'(ks_bit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    chk("rst_stay_idle", 32'({busy, ks_valid, done}), 32'd0);
  endtask

`ifdef A5_1_ABORT_EN
  task automatic abort_at(input int when);
    logic saw_done;
    saw_done = 1'b0;
    exp_q.delete();
    push_bits(gold);
    ks_ready = 1'b1;
    launch(gold_key, gold_frame);
    while (cyc < when) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    saw_done = done;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(ks_valid), 32'd0);
    chk("abort_bit", 32'(ks_bit), 32'd0);
    exp_q.delete();
    repeat (5) begin
      tick();
      saw_done = saw_done | done;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    ks_ready = 1'b0;
    key      = '0;
    frame    = '0;
`ifdef A5_1_ABORT_EN
    abort    = 1'b0;
`endif
    gold_key   = 64'hEFCDAB8967452312;
    gold_frame = 22'h134;
    hex_ab     = 120'h534EAA582FE8151AB6E1855A728C00;
    hex_ba     = 120'h24FD35A35D5FB6526D32F906DF1AC0;
    gold       = {hex_ab[119:6], hex_ba[119:6]};
    zero_bits  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(ks_valid), 32'd0);
    chk("reset_bit", 32'(ks_bit), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    run_frame(gold_key, gold_frame, gold, 1'b0, 1'b0);
    run_frame(gold_key, gold_frame, gold, 1'b1, 1'b0);
    run_frame(gold_key, gold_frame, gold, 1'b0, 1'b1);

    reset_at(100);
    reset_at(200);
    run_frame(gold_key, gold_frame, gold, 1'b0, 1'b0);

    run_frame('0, '0, zero_bits, 1'b0, 1'b0);

`ifdef A5_1_ABORT_EN
    abort_at(150);
    run_frame(gold_key, gold_frame, gold, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a5_1_keystream.md
# a5_1_keystream

A5/1 keystream engine built on three feedback shift registers (R1/R2/R3). It is the producer side of the register's serial load interface. On `start` it captures a 64-bit session key and a 22-bit frame number, then drives each register's serial input and clock enable through the key-load, frame-load and mixing phases. It then streams keystream bits to the cipher datapath over a valid/ready handshake.

## Interface
- `NUM_KS_BITS`, 228: keystream bits per frame (A→B then B→A); legal range 1..1023.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: begin a frame; honoured only in IDLE.
- `key` input 64: session key; `key[0]` is loaded first.
- `frame` input 22: frame number; `frame[0]` is loaded first.
- `ks_ready` input 1: consumer accepts `ks_bit` this cycle.
- `ks_valid` output 1: `ks_bit` is valid.
- `ks_bit` output 1: keystream bit, equal to R1[18]^R2[21]^R3[22].
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last keystream bit is accepted.

## Operation
- Register definitions:
  - R1: 19 bits, taps 13/16/17/18, clocking bit 8.
  - R2: 22 bits, taps 20/21, clocking bit 10.
  - R3: 23 bits, taps 7/20/21/22, clocking bit 10.
- A register step shifts left. The new bit 0 is the tap XOR, XORed with the serial input `d`.
- FSM states: IDLE → LOAD_KEY → LOAD_FRAME → MIX → OUT → DONE → IDLE.
- IDLE: `start`=1 captures `key`/`frame` into internal copies, zeroes R1/R2/R3, sets the bit counter to 0, and moves to LOAD_KEY. After capture, the inputs may change freely.
- LOAD_KEY: 64 cycles. All three registers step every cycle with `d`=key_copy[cnt].
- LOAD_FRAME: 22 cycles. All three step every cycle with `d`=frame_copy[cnt].
- MIX: 101 cycles of majority clocking with `d`=0. Output is discarded.
  - maj = majority of R1[8], R2[10], R3[10].
  - Each register steps only if its clocking bit equals maj.
  - 101 = the 100 standard discard clocks plus the clock that precedes the first output bit.
- OUT: `ks_valid`=1 and `ks_bit` is combinational from the register MSBs.
  - On `ks_valid & ks_ready`: one majority clock and counter+1.
  - After the NUM_KS_BITS-th accept, move to DONE.
  - `ks_ready`=0 stalls with no register change.
- DONE: `done`=1 for one cycle, then IDLE. Registers hold their last state until the next `start`.
- `start` while busy is ignored; captured values are not disturbed.
- `reset_n`=0 in any state, mid-frame included, on the next edge:
  - state=IDLE, all registers and counters cleared;
  - outputs `ks_valid`=0, `ks_bit`=0, `busy`=0, `done`=0.
  - No partial keystream is emitted after reset.
- One shared counter, 10 bits wide, is reused across phases and cleared on every phase transition. No arithmetic wider than this counter.

## Timing
- `start` sampled at edge 0. LOAD_KEY occupies cycles 1–64, LOAD_FRAME 65–86, MIX 87–187.
- First `ks_valid` is in cycle 188, a fixed 187-cycle latency from `start`.
- With `ks_ready` held high: one bit per cycle; last bit in cycle 187+NUM_KS_BITS; `done` in the following cycle; `busy` drops with it.
- `busy` rises in cycle 1.
- `ks_bit` is stable whenever `ks_valid`=1 and `ks_ready`=0.

## Configuration
- `A5_1_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort`=1 in any non-IDLE state returns to IDLE on the next edge and zeroes all registers.
  - `done` is not pulsed.
  - `abort` has priority over `start` and the handshake; `reset_n` has priority over `abort`.
- Not defined: no `abort` port. A frame always runs to DONE unless reset.

## Structure
- Shared package `a5_1_pkg`:
  - register lengths (19/22/23);
  - tap masks: R1 19'h72000, R2 22'h300000, R3 23'h700080;
  - clocking-bit indices;
  - phase lengths (64/22/101);
  - state enum.
- One sub-module, `a5_1_reg`, instantiated three times. It is parameterised by length and tap mask and has ports `clk`, `reset_n` (sync), `clr`, `step`, `d`, `q_msb`, `q_clk` (clocking bit).
- FSM, counter and majority logic live in the top.

## Test plan
- Golden vector: key=64'hEFCDAB8967452312, frame=22'h134, `ks_ready`=1.
  - Bits 0–113 (first bit = MSB of first hex digit) = 534EAA582FE8151AB6E1855A728C00 (114 bits).
  - Bits 114–227 = 24FD35A35D5FB6526D32F906DF1AC0.
  - `done` in cycle 416.
- Backpressure: same vector with `ks_ready` randomly low ~50% → identical bit sequence; `ks_bit` held during stalls; `done` only after the 228th accept.
- Latency/ignore: pulse `start` again in cycles 5 and 190 → ignored; first `ks_valid` still in cycle 188; output unchanged.
- Reset mid-frame: assert `reset_n`=0 in cycle 100 (MIX) and in cycle 200 (OUT) → next cycle all outputs 0 and state IDLE. A fresh `start` then reproduces the golden vector.
- All-zero key and frame=0 → registers remain zero; 228 bits all 0; `done` in cycle 416.
- With `A5_1_ABORT_EN`: `abort` in cycle 150 → IDLE next cycle, no `done`, `busy`=0. A subsequent golden run passes.
